// File: rtl/calc_scheduler.sv
// calc_scheduler: round-robin arbiter and launch sequencer for the watchdog calculation core.
// Port 0 is the pin-driven parameter loader, port 1 the periodic self-check source. A granted
// job is launched with latched operands, the core busy handshake is tracked, and completion is
// reported with the owner ID.
// Optional feature: define SCHED_TIMEOUT_EN to enable the ACK/RUN watchdog counters, done_err
// and err_sticky. Without it the scheduler waits on the core indefinitely and errors read 0.
module calc_scheduler #(
    parameter int unsigned W              = 32,
    parameter int unsigned ACK_WAIT       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ena_i,
    input  logic                req0_i,
    input  logic                req1_i,
    input  logic signed [W-1:0] a0_0_i,
    input  logic signed [W-1:0] a1_0_i,
    input  logic signed [W-1:0] a0_1_i,
    input  logic signed [W-1:0] a1_1_i,
    output logic                gnt0_o,
    output logic                gnt1_o,
    output logic                core_start_o,
    output logic signed [W-1:0] core_a0_o,
    output logic signed [W-1:0] core_a1_o,
    input  logic                core_busy_i,
    output logic                done_o,
    output logic                done_id_o,
    output logic                done_err_o,
    output logic                err_sticky_o,
    input  logic                err_clr_i
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StAck,
        StRun,
        StDone
    } state_e;

    state_e              state_q;
    logic                start_q;
    logic                gnt0_q;
    logic                gnt1_q;
    logic                done_q;
    logic                done_id_q;
    logic                done_err_q;
    logic                err_sticky_q;
    logic                owner_q;
    logic                last_grant_q;
    logic signed [W-1:0] core_a0_q;
    logic signed [W-1:0] core_a1_q;
    logic                req_any;
    logic                grant_sel;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] AckLast = CntW'(ACK_WAIT - 1);
    localparam logic [CntW-1:0] RunLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;

    // Saturating increment of the handshake watchdog counter.
    always_comb begin
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    end
`else
    // Without watchdogs the timing limits and the error clear have no effect.
    localparam int unsigned unused_cfg = ACK_WAIT + TIMEOUT_CYCLES;
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
`endif

    // Round-robin pick: a lone request wins; on a tie the port not granted last wins.
    always_comb begin
        req_any = req0_i | req1_i;
        if (req0_i && req1_i) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = req1_i;
        end
    end

    // Sequencer FSM with registered pulses; ena_i low freezes every register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            start_q      <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
            done_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            core_a0_q    <= '0;
            core_a1_q    <= '0;
`ifdef SCHED_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else if (ena_i) begin
            start_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            // A timeout set later in this block overrides a simultaneous clear.
            if (err_clr_i) begin
                err_sticky_q <= 1'b0;
            end
`endif
            case (state_q)
                StIdle: begin
                    if (!core_busy_i && req_any) begin
                        core_a0_q    <= grant_sel ? a0_1_i : a0_0_i;
                        core_a1_q    <= grant_sel ? a1_1_i : a1_0_i;
                        owner_q      <= grant_sel;
                        last_grant_q <= grant_sel;
                        start_q      <= 1'b1;
                        gnt0_q       <= ~grant_sel;
                        gnt1_q       <= grant_sel;
                        state_q      <= StLaunch;
                    end
                end
                StLaunch: begin
`ifdef SCHED_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    state_q <= StAck;
                end
                StAck: begin
                    if (core_busy_i) begin
`ifdef SCHED_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                        state_q <= StRun;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (cnt_q >= AckLast) begin
                        err_sticky_q <= 1'b1;
                        done_q       <= 1'b1;
                        done_id_q    <= owner_q;
                        done_err_q   <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
`endif
                end
                StRun: begin
                    if (!core_busy_i) begin
                        done_q     <= 1'b1;
                        done_id_q  <= owner_q;
                        done_err_q <= 1'b0;
                        state_q    <= StDone;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (cnt_q >= RunLast) begin
                        err_sticky_q <= 1'b1;
                        done_q       <= 1'b1;
                        done_id_q    <= owner_q;
                        done_err_q   <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Pulses held through a freeze are masked until ena_i returns.
    assign core_start_o = start_q & ena_i;
    assign gnt0_o       = gnt0_q & ena_i;
    assign gnt1_o       = gnt1_q & ena_i;
    assign done_o       = done_q & ena_i;
    assign done_id_o    = done_id_q;
    assign done_err_o   = done_err_q;
    assign err_sticky_o = err_sticky_q;
    assign core_a0_o    = core_a0_q;
    assign core_a1_o    = core_a1_q;

endmodule

// File: tb/tb_calc_scheduler.sv
// Directed self-checking bench for calc_scheduler (ACK_WAIT=4, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_calc_scheduler;

    localparam int unsigned W             = 32;
    localparam int unsigned AckWait       = 4;
    localparam int unsigned TimeoutCycles = 16;

    logic                clk;
    logic                rst_n;
    logic                ena;
    logic                req0;
    logic                req1;
    logic signed [W-1:0] a0_0;
    logic signed [W-1:0] a1_0;
    logic signed [W-1:0] a0_1;
    logic signed [W-1:0] a1_1;
    logic                gnt0;
    logic                gnt1;
    logic                core_start;
    logic signed [W-1:0] core_a0;
    logic signed [W-1:0] core_a1;
    logic                core_busy;
    logic                done;
    logic                done_id;
    logic                done_err;
    logic                err_sticky;
    logic                err_clr;

    int n_checks;
    int n_errors;

    calc_scheduler #(
        .W             (W),
        .ACK_WAIT      (AckWait),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ena_i       (ena),
        .req0_i      (req0),
        .req1_i      (req1),
        .a0_0_i      (a0_0),
        .a1_0_i      (a1_0),
        .a0_1_i      (a0_1),
        .a1_1_i      (a1_1),
        .gnt0_o      (gnt0),
        .gnt1_o      (gnt1),
        .core_start_o(core_start),
        .core_a0_o   (core_a0),
        .core_a1_o   (core_a1),
        .core_busy_i (core_busy),
        .done_o      (done),
        .done_id_o   (done_id),
        .done_err_o  (done_err),
        .err_sticky_o(err_sticky),
        .err_clr_i   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits for a launch, plays a core that is busy for busy_len cycles from the ACK cycle,
    // then waits for done. ok drops if either wait runs out.
    task automatic run_job(input int busy_len, output logic g0, output logic g1,
                           output logic [W-1:0] a0, output logic [W-1:0] a1,
                           output logic d_id, output logic d_err, output bit ok);
        int t;
        ok = 1'b1; g0 = 1'b0; g1 = 1'b0; a0 = '0; a1 = '0; d_id = 1'b0; d_err = 1'b0;
        t = 0;
        while (!core_start && t < 10) begin tick(); t++; end
        if (!core_start) begin ok = 1'b0; return; end
        g0 = gnt0; g1 = gnt1; a0 = core_a0; a1 = core_a1;
        core_busy = 1'b0;
        tick();
        core_busy = 1'b1;
        repeat (busy_len) tick();
        core_busy = 1'b0;
        t = 0;
        while (!done && t < 10) begin tick(); t++; end
        if (!done) begin ok = 1'b0; return; end
        d_id = done_id; d_err = done_err;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic           seen;
        logic           g0, g1, did, derr;
        logic [W-1:0]   ja0, ja1;
        bit             ok;
        int             exp_id;

        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; ena = 1'b1; req0 = 1'b0; req1 = 1'b0; core_busy = 1'b0; err_clr = 1'b0;
        a0_0 = 0; a1_0 = 0; a0_1 = 0; a1_1 = 0;

        // Reset state
        tick(); tick();
        check_eq("rst gnt0", W'(gnt0), 0);
        check_eq("rst gnt1", W'(gnt1), 0);
        check_eq("rst start", W'(core_start), 0);
        check_eq("rst done", W'(done), 0);
        check_eq("rst a0", core_a0, 0);
        check_eq("rst sticky", W'(err_sticky), 0);
        rst_n = 1'b1;
        tick();

        // Single request from port 0, 3-cycle busy
        a0_0 = 5; a1_0 = -3; a0_1 = 100; a1_1 = 200; req0 = 1'b1;
        tick();
        check_eq("t1 start", W'(core_start), 1);
        check_eq("t1 gnt0", W'(gnt0), 1);
        check_eq("t1 gnt1", W'(gnt1), 0);
        check_eq("t1 a0", core_a0, 5);
        check_eq("t1 a1", core_a1, -3);
        req0 = 1'b0;
        tick(); core_busy = 1'b1;
        tick(); tick();
        tick(); core_busy = 1'b0;
        check_eq("t1 done early", W'(done), 0);
        tick();
        check_eq("t1 done", W'(done), 1);
        check_eq("t1 done_id", W'(done_id), 0);
        check_eq("t1 done_err", W'(done_err), 0);
        tick();
        check_eq("t1 done one cycle", W'(done), 0);
        check_eq("t1 a0 stable", core_a0, 5);

`ifdef SCHED_TIMEOUT_EN
        // Core never acknowledges: error done at launch+5, then sticky clear
        a0_1 = 7; a1_1 = -9; req1 = 1'b1;
        tick();
        check_eq("ackto start", W'(core_start), 1);
        check_eq("ackto gnt1", W'(gnt1), 1);
        req1 = 1'b0;
        seen = 1'b0;
        repeat (4) begin tick(); seen |= done; end
        check_eq("ackto early done", W'(seen), 0);
        tick();
        check_eq("ackto done", W'(done), 1);
        check_eq("ackto done_err", W'(done_err), 1);
        check_eq("ackto done_id", W'(done_id), 1);
        check_eq("ackto sticky", W'(err_sticky), 1);
        tick();
        check_eq("ackto sticky held", W'(err_sticky), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("ackto sticky cleared", W'(err_sticky), 0);

        // Busy stuck high: timeout after 16 run cycles; err_clr held loses to the set
        a0_0 = 11; a1_0 = 12; req0 = 1'b1;
        tick();
        check_eq("runto start", W'(core_start), 1);
        req0 = 1'b0;
        tick(); core_busy = 1'b1; err_clr = 1'b1;
        seen = 1'b0;
        repeat (16) begin tick(); seen |= done; end
        check_eq("runto early done", W'(seen), 0);
        tick();
        check_eq("runto done", W'(done), 1);
        check_eq("runto done_err", W'(done_err), 1);
        check_eq("runto done_id", W'(done_id), 0);
        check_eq("runto sticky set wins", W'(err_sticky), 1);
        err_clr = 1'b0; req1 = 1'b1;
        tick();
        check_eq("runto no grant busy a", W'(core_start), 0);
        tick();
        check_eq("runto no grant busy b", W'(core_start), 0);
        core_busy = 1'b0;
        tick();
        check_eq("runto regrant start", W'(core_start), 1);
        check_eq("runto regrant gnt1", W'(gnt1), 1);
        req1 = 1'b0;
        tick(); core_busy = 1'b1;
        tick(); core_busy = 1'b0;
        tick();
        check_eq("runto next done", W'(done), 1);
        check_eq("runto next id", W'(done_id), 1);
        check_eq("runto next err", W'(done_err), 0);
`else
        // Without watchdogs a silent core is waited on indefinitely
        a0_1 = 7; a1_1 = -9; req1 = 1'b1;
        tick();
        check_eq("noto start", W'(core_start), 1);
        check_eq("noto gnt1", W'(gnt1), 1);
        req1 = 1'b0;
        seen = 1'b0;
        repeat (20) begin tick(); seen |= done; end
        check_eq("noto no done", W'(seen), 0);
        check_eq("noto sticky", W'(err_sticky), 0);
        core_busy = 1'b1;
        tick(); core_busy = 1'b0;
        tick();
        check_eq("noto done", W'(done), 1);
        check_eq("noto done_id", W'(done_id), 1);
        check_eq("noto done_err", W'(done_err), 0);
`endif

        // Reset mid-run aborts the job with no done pulse
        tick();
        a0_1 = 32'h55; a1_1 = 32'hAA; req1 = 1'b1;
        tick();
        check_eq("rstrun start", W'(core_start), 1);
        req1 = 1'b0;
        tick(); core_busy = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check_eq("rstrun a0", core_a0, 0);
        check_eq("rstrun a1", core_a1, 0);
        check_eq("rstrun done_id", W'(done_id), 0);
        check_eq("rstrun done_err", W'(done_err), 0);
        check_eq("rstrun sticky", W'(err_sticky), 0);
        check_eq("rstrun start", W'(core_start), 0);
        rst_n = 1'b1; core_busy = 1'b0;
        seen = 1'b0;
        repeat (4) begin tick(); seen |= done; end
        check_eq("rstrun no done", W'(seen), 0);

        // Tied requests alternate starting with port 0
        a0_0 = 10; a1_0 = 11; a0_1 = 20; a1_1 = 21;
        req0 = 1'b1; req1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_id = j % 2;
            run_job(2, g0, g1, ja0, ja1, did, derr, ok);
            check_eq($sformatf("tie%0d ok", j), W'(ok), 1);
            check_eq($sformatf("tie%0d gnt0", j), W'(g0), W'(exp_id == 0));
            check_eq($sformatf("tie%0d gnt1", j), W'(g1), W'(exp_id == 1));
            check_eq($sformatf("tie%0d a0", j), ja0, (exp_id == 1) ? 20 : 10);
            check_eq($sformatf("tie%0d a1", j), ja1, (exp_id == 1) ? 21 : 11);
            check_eq($sformatf("tie%0d done_id", j), W'(did), W'(exp_id));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Freeze mid-run with busy falling during the freeze
        a0_0 = 1234; a1_0 = -1; req0 = 1'b1;
        tick();
        check_eq("frzA start", W'(core_start), 1);
        req0 = 1'b0;
        tick(); core_busy = 1'b1;
        tick(); tick();
        tick(); ena = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) core_busy = 1'b0;
            #1 seen |= done;
            tick();
        end
        check_eq("frzA no done frozen", W'(seen), 0);
        ena = 1'b1;
        #1 check_eq("frzA no done resume", W'(done), 0);
        tick();
        check_eq("frzA done", W'(done), 1);
        check_eq("frzA done_id", W'(done_id), 0);
        check_eq("frzA done_err", W'(done_err), 0);
        tick();

        // Freeze during the launch cycle holds the start pulse until ena returns
        a0_1 = 77; a1_1 = -77; req1 = 1'b1;
        tick();
        ena = 1'b0;
        #1 check_eq("frzC start masked", W'(core_start), 0);
        check_eq("frzC gnt1 masked", W'(gnt1), 0);
        seen = 1'b0;
        repeat (3) begin tick(); seen |= core_start | gnt1; end
        check_eq("frzC no pulse frozen", W'(seen), 0);
        ena = 1'b1;
        #1 check_eq("frzC start resumed", W'(core_start), 1);
        check_eq("frzC gnt1 resumed", W'(gnt1), 1);
        check_eq("frzC a0", core_a0, 77);
        req1 = 1'b0;
        tick(); core_busy = 1'b1;
        tick(); core_busy = 1'b0;
        tick();
        check_eq("frzC done", W'(done), 1);
        check_eq("frzC done_id", W'(done_id), 1);
        tick();

`ifdef SCHED_TIMEOUT_EN
        // Frozen run counter: timeout lands 10 cycles later than unfrozen
        a0_0 = 3; a1_0 = 4; req0 = 1'b1;
        tick();
        check_eq("frzB start", W'(core_start), 1);
        req0 = 1'b0;
        tick(); core_busy = 1'b1;
        tick(); tick();
        tick(); ena = 1'b0;
        repeat (10) tick();
        ena = 1'b1;
        seen = 1'b0;
        repeat (13) begin tick(); seen |= done; end
        check_eq("frzB early done", W'(seen), 0);
        tick();
        check_eq("frzB done", W'(done), 1);
        check_eq("frzB done_err", W'(done_err), 1);
        core_busy = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_scheduler.md
# calc_scheduler

Sequencer and arbiter for the watchdog calculation core. Two parameter sources compete for the single core: port 0 is the pin-driven parameter loader, and port 1 is the periodic self-check source. The block grants requests round-robin, launches the core with the granted operands, and tracks the core's busy handshake. It reports completion or timeout with the owner ID.

## Interface
- W, 32, operand width (signed)
- ACK_WAIT, 4, max cycles from core_start to core_busy rising
- TIMEOUT_CYCLES, 1024, max cycles core_busy may stay high
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; low = freeze
- req0 / req1  in  1  request level; hold until matching gnt pulse
- a0_0, a1_0 / a0_1, a1_1  in  W  signed operands of requester 0 / 1
- gnt0 / gnt1  out  1  one-cycle grant pulse
- core_start  out  1  one-cycle launch pulse to core
- core_a0, core_a1  out  W  latched operands to core, stable from launch to next grant
- core_busy  in  1  core busy level
- done  out  1  one-cycle completion pulse
- done_id  out  1  owner of the finished job, valid with done
- done_err  out  1  job ended by timeout, valid with done
- err_sticky  out  1  set on any timeout, cleared by err_clr or reset
- err_clr  in  1  clears err_sticky

## Operation
- States: S_IDLE, S_LAUNCH, S_ACK, S_RUN, S_DONE.
- S_IDLE
  - Requires ena=1, core_busy=0, and (req0|req1).
  - Arbitration: if only one request is pending, it wins. If both are pending, the requester not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
  - Latches the winner's operands into core_a0/core_a1, sets owner, updates last_grant, and moves to S_LAUNCH.
- S_LAUNCH: core_start=1 and gnt<owner>=1 for this cycle. Clears the counter and moves to S_ACK.
- S_ACK
  - core_busy=1: clear counter, go to S_RUN.
  - Otherwise increment the counter. At ACK_WAIT, set err and go to S_DONE.
- S_RUN
  - core_busy=0: go to S_DONE.
  - Otherwise increment the counter. At TIMEOUT_CYCLES, set err and go to S_DONE.
- S_DONE: done=1, done_id=owner, done_err=err. Clears err and returns to S_IDLE.
- err_sticky:
  - Set in the cycle a timeout is detected.
  - err_clr in the same cycle loses; set wins.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- A request still high after its gnt is treated as a new request at the next S_IDLE.

## Timing
- Reset (rst_n=0 at an edge) applies in every state, including mid-job:
  - state=S_IDLE; all pulses 0; core_a0=core_a1=0; done_id=0; done_err=0; err_sticky=0; counter=0; last_grant=1.
  - No done pulse is issued for an aborted job.
- Request sampled in S_IDLE at cycle N → core_start, gnt, and new core_a0/a1 all visible in cycle N+1.
- core_busy first seen high at cycle M → S_RUN from M+1.
- core_busy seen low in S_RUN at cycle K → done high in K+1.
- Minimum request-to-done: 4 cycles (busy seen high 1 cycle after launch, 1-cycle job). Back-to-back grant: the cycle after done at the earliest.
- ACK timeout: done with done_err=1 in cycle launch+ACK_WAIT+1.
- ena=0: state, counter, and registers hold. core_start, gnt0/1, and done are forced 0. A pulse due during a freeze is emitted once ena returns.

## Configuration
- SCHED_TIMEOUT_EN
  - Defined: S_ACK and S_RUN counters and timeouts active as above.
  - Undefined: no counters. S_ACK and S_RUN wait indefinitely; done_err and err_sticky are tied 0; err_clr is ignored.

## Test plan
- req0=1, a0_0=5, a1_0=-3; core raises busy 1 cycle after start, busy 3 cycles → gnt0 and core_start at N+1, core_a0=5, core_a1=-3, done with done_id=0 and done_err=0.
- req0 and req1 high together, repeated 4 jobs → grants alternate 0,1,0,1.
- Core never raises busy, ACK_WAIT=4 → done_err=1 and err_sticky=1 at launch+5; err_clr=1 one cycle later → err_sticky=0.
- Busy stuck high, TIMEOUT_CYCLES=16 → done_err=1 after 16 S_RUN cycles; a new request is granted after S_IDLE is reached.
- rst_n=0 for 1 cycle during S_RUN → all outputs zero next cycle, no done pulse, next tie goes to port 0.
- ena=0 for 10 cycles mid-S_RUN with busy falling during the freeze → done appears only after ena=1; counter unchanged across the freeze.
